// File: rtl/conv_func_stream.sv
// Functional unit for a CIM layer: reads crossbar columns, sums the vertical tiles, requantises
// (shift, optional ReLU, saturate) and streams words out through a credit-limited FIFO.
module conv_func_stream #(
    parameter int unsigned OutputSize         = 512,
    parameter int unsigned XbarSize           = 256,
    parameter int unsigned VCimTiles          = 2,
    parameter int unsigned HCimTiles          = (OutputSize + XbarSize - 1) / XbarSize,
    parameter int unsigned DatatypeSize       = 8,
    parameter int unsigned OutputDatatypeSize = 8,
    parameter int unsigned CimLatency         = 2,
    parameter int unsigned FifoDepth          = CimLatency + 2,
    parameter int unsigned OutShift           = 0,
    parameter bit          ReluEn             = 1'b1,
    localparam int unsigned AddrW  = (XbarSize > 1) ? $clog2(XbarSize) : 1,
    localparam int unsigned HtileW = (HCimTiles > 1) ? $clog2(HCimTiles) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_start,
    input  logic                                i_cim_busy,
    output logic                                o_cim_re,
    output logic [AddrW-1:0]                    o_cim_addr,
    output logic [HtileW-1:0]                   o_cim_htile,
    input  logic [VCimTiles*DatatypeSize-1:0]   i_data,
    output logic [OutputDatatypeSize-1:0]       o_data,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic                                o_busy,
    output logic                                o_done
);

    localparam int unsigned SumW      = DatatypeSize + $clog2(VCimTiles + 1);
    localparam int unsigned OutW      = OutputDatatypeSize;
    localparam int unsigned CmpW      = ((SumW > OutW) ? SumW : OutW) + 1;
    localparam int unsigned PtrW      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW      = $clog2(FifoDepth + CimLatency + 1) + 1;
    localparam int unsigned LastAddr  = (OutputSize - 1) % XbarSize;
    localparam int unsigned LastHtile = (OutputSize - 1) / XbarSize;
    localparam logic signed [CmpW-1:0] MaxVal = {{(CmpW-OutW+1){1'b0}}, {(OutW-1){1'b1}}};
    localparam logic signed [CmpW-1:0] MinVal = {{(CmpW-OutW+1){1'b1}}, {(OutW-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StWaitCim, StIssue, StDrain, StDone} state_e;

    state_e                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic [AddrW-1:0]       r_addr;
    logic [HtileW-1:0]      r_htile;
    logic [CimLatency-1:0]  r_pipe;
    logic [CntW-1:0]        r_inflight;
    logic [CntW-1:0]        r_count;
    logic [PtrW-1:0]        r_wptr;
    logic [PtrW-1:0]        r_rptr;
    logic [OutW-1:0]        r_mem [FifoDepth];

    logic                   w_re;
    logic                   w_cap;
    logic                   w_last;
    logic                   w_credit;
    logic                   w_empty;
    logic                   w_fire;
    logic                   w_push;
    logic                   w_pop;
    logic [DatatypeSize-1:0] w_tile;
    logic signed [SumW-1:0] w_sum;
    logic signed [SumW-1:0] w_shift;
    logic signed [CmpW-1:0] w_ext;
    logic [OutW-1:0]        w_result;
    logic [OutW-1:0]        w_head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign w_credit = (r_inflight + r_count) < CntW'(FifoDepth);
    assign w_re     = (r_state == StIssue) && !i_cim_busy && w_credit;
    assign w_cap    = r_pipe[CimLatency-1];
    assign w_last   = (r_addr == AddrW'(LastAddr)) && (r_htile == HtileW'(LastHtile));

    assign o_cim_re    = w_re;
    assign o_cim_addr  = r_addr;
    assign o_cim_htile = r_htile;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    always_comb begin
        w_tile = '0;
        w_sum  = '0;
        for (int i = 0; i < VCimTiles; i++) begin
            w_tile = i_data[i*DatatypeSize +: DatatypeSize];
            w_sum  = w_sum + {{(SumW-DatatypeSize){w_tile[DatatypeSize-1]}}, w_tile};
        end
        w_shift = w_sum >>> OutShift;
        w_ext   = {{(CmpW-SumW){w_shift[SumW-1]}}, w_shift};
        if (ReluEn && w_ext[CmpW-1]) begin
            w_ext = '0;
        end
        if (w_ext > MaxVal) begin
            w_result = MaxVal[OutW-1:0];
        end else if (w_ext < MinVal) begin
            w_result = MinVal[OutW-1:0];
        end else begin
            w_result = w_ext[OutW-1:0];
        end
    end

    // An empty FIFO forwards the word being captured so the first result appears
    // cim_latency cycles after its read; it is only stored if the consumer stalls.
    assign w_empty = (r_count == '0);
    assign o_valid = !w_empty || w_cap;
    assign w_head  = w_empty ? w_result : r_mem[r_rptr];
    assign o_data  = o_valid ? w_head : '0;
    assign w_fire  = o_valid && i_ready;
    assign w_pop   = w_fire && !w_empty;
    assign w_push  = w_cap && !(w_empty && i_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_htile <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_addr  <= '0;
                        r_htile <= '0;
                        r_busy  <= 1'b1;
                        r_state <= i_cim_busy ? StWaitCim : StIssue;
                    end
                end
                StWaitCim: begin
                    if (!i_cim_busy) begin
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    if (w_re) begin
                        if (w_last) begin
                            r_state <= StDrain;
                        end else if (r_addr == AddrW'(XbarSize - 1)) begin
                            r_addr  <= '0;
                            r_htile <= r_htile + HtileW'(1);
                        end else begin
                            r_addr <= r_addr + AddrW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (r_inflight == '0 && r_count == '0) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe     <= '0;
            r_inflight <= '0;
        end else begin
            r_pipe[0] <= w_re;
            for (int i = 1; i < CimLatency; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            unique case ({w_re, w_cap})
                2'b10:   r_inflight <= r_inflight + CntW'(1);
                2'b01:   r_inflight <= r_inflight - CntW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_result;
        end
    end

endmodule

// File: tb/tb_conv_func_stream.sv
// Bench for conv_func_stream: a default instance plus a small shift=2 / no-ReLU instance,
// driven by a crossbar model that answers each read two cycles after its strobe.
module tb_conv_func_stream;

    localparam int Lat = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_cim_busy, i_ready;
    logic [15:0] i_data;
    logic        o_cim_re, o_valid, o_busy, o_done;
    logic [7:0]  o_cim_addr, o_data;
    logic [0:0]  o_cim_htile;

    logic        i_start2, i_cim_busy2, i_ready2;
    logic [15:0] i_data2;
    logic        o_cim_re2, o_valid2, o_busy2, o_done2;
    logic [1:0]  o_cim_addr2;
    logic [0:0]  o_cim_htile2;
    logic [7:0]  o_data2;

    always #5 clk = ~clk;

    conv_func_stream dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_cim_busy(i_cim_busy),
        .o_cim_re(o_cim_re), .o_cim_addr(o_cim_addr), .o_cim_htile(o_cim_htile),
        .i_data(i_data), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    conv_func_stream #(.OutputSize(8), .XbarSize(4), .OutShift(2), .ReluEn(1'b0)) dut2 (
        .clk(clk), .rst(rst), .i_start(i_start2), .i_cim_busy(i_cim_busy2),
        .o_cim_re(o_cim_re2), .o_cim_addr(o_cim_addr2), .o_cim_htile(o_cim_htile2),
        .i_data(i_data2), .o_data(o_data2), .o_valid(o_valid2), .i_ready(i_ready2),
        .o_busy(o_busy2), .o_done(o_done2)
    );

    typedef struct {
        int a;
        int b;
        int e_def;
        int e_alt;
    } vec_t;
    vec_t tbl [8];

    int n_chk = 0, n_pass = 0, cyc = 0, mode = 0;
    logic nx_start = 0, nx_busy = 0, nx_ready = 1, nx_start2 = 0;
    int issued, recv, done1, first_re, first_valid, prev_data;
    int issued2, recv2, done2;
    bit prev_stall;
    bit hv1 [8];
    bit hv2 [8];
    int hn1 [8];
    int hn2 [8];
    int s_re, s_busy, s_valid;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] xdata(input int m, input int n);
        logic [7:0] a, b;
        if (m == 0) begin
            a = 8'd10; b = 8'd20;
        end else if (m == 1) begin
            a = 8'(tbl[n % 8].a); b = 8'(tbl[n % 8].b);
        end else begin
            a = 8'(n % 128); b = 8'd0;
        end
        return {b, a};
    endfunction

    function automatic int exp1(input int n);
        if (mode == 0) return 30;
        else if (mode == 1) return tbl[n % 8].e_def;
        else return n % 128;
    endfunction

    task automatic pass_init();
        issued = 0; recv = 0; done1 = 0; first_re = -1; first_valid = -1; prev_stall = 0;
        issued2 = 0; recv2 = 0; done2 = 0;
        for (int i = 0; i < 8; i++) begin
            hv1[i] = 0; hv2[i] = 0;
        end
    endtask

    // One clock cycle: apply inputs, answer reads issued Lat cycles ago, then sample outputs.
    task automatic tick();
        int k;
        @(posedge clk);
        #1;
        cyc++;
        i_start = nx_start; i_ready = nx_ready; i_cim_busy = nx_busy; i_start2 = nx_start2;
        k = (cyc + 8 - Lat) % 8;
        i_data  = hv1[k] ? xdata(mode, hn1[k]) : 16'h5a5a;
        i_data2 = hv2[k] ? xdata(1, hn2[k]) : 16'h5a5a;
        #1;
        if (o_cim_re) begin
            if (first_re < 0) first_re = cyc;
            chk("addr", int'(o_cim_addr), issued % 256);
            chk("htile", int'(o_cim_htile), issued / 256);
            hv1[cyc % 8] = 1; hn1[cyc % 8] = issued; issued++;
        end else begin
            hv1[cyc % 8] = 0;
        end
        if (prev_stall) begin
            chk("hold_valid", int'(o_valid), 1);
            chk("hold_data", int'($signed(o_data)), prev_data);
        end
        if (o_valid && i_ready) begin
            if (first_valid < 0) first_valid = cyc;
            chk("data", int'($signed(o_data)), exp1(recv));
            recv++;
        end
        prev_stall = o_valid && !i_ready;
        prev_data  = int'($signed(o_data));
        if (o_done) begin
            done1++;
            chk("busy_in_done", int'(o_busy), 0);
        end
        s_re = int'(o_cim_re); s_busy = int'(o_busy); s_valid = int'(o_valid);

        if (o_cim_re2) begin
            chk("addr2", int'(o_cim_addr2), issued2 % 4);
            chk("htile2", int'(o_cim_htile2), issued2 / 4);
            hv2[cyc % 8] = 1; hn2[cyc % 8] = issued2; issued2++;
        end else begin
            hv2[cyc % 8] = 0;
        end
        if (o_valid2 && i_ready2) begin
            chk("data2", int'($signed(o_data2)), tbl[recv2 % 8].e_alt);
            recv2++;
        end
        if (o_done2) done2++;
    endtask

    task automatic run_until_done(input int budget, input bit both);
        int i = 0;
        while ((done1 == 0 || (both && done2 == 0)) && i < budget) begin
            tick();
            i++;
        end
        chk("timeout", (done1 != 0) ? 1 : 0, 1);
        if (both) chk("timeout2", (done2 != 0) ? 1 : 0, 1);
    endtask

    task automatic pass_end();
        chk("issued", issued, 512);
        chk("received", recv, 512);
        chk("done_count", done1, 1);
    endtask

    task automatic start_pass(input int m);
        mode = m;
        pass_init();
        nx_start = 1;
        tick();
        nx_start = 0;
    endtask

    initial begin
        tbl[0] = '{10, 20, 30, 7};
        tbl[1] = '{100, 100, 127, 50};
        tbl[2] = '{-50, -30, 0, -20};
        tbl[3] = '{40, 24, 64, 16};
        tbl[4] = '{-128, -128, 0, -64};
        tbl[5] = '{127, 127, 127, 63};
        tbl[6] = '{-100, -100, 0, -50};
        tbl[7] = '{-1, 0, 0, -1};

        rst = 1'b0;
        i_start = 0; i_cim_busy = 0; i_ready = 1; i_data = '0;
        i_start2 = 0; i_cim_busy2 = 0; i_ready2 = 1; i_data2 = '0;
        pass_init();
        #3;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_re", int'(o_cim_re), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_addr", int'(o_cim_addr), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;

        // Constant {10,20}: 512 words of 30, address wrap, latency, single done.
        start_pass(0);
        tick();
        chk("busy_after_start", s_busy, 1);
        run_until_done(700, 0);
        repeat (3) tick();
        pass_end();
        chk("first_latency", first_valid - first_re, Lat);

        // Arithmetic vectors on both instances.
        mode = 1;
        pass_init();
        nx_start = 1; nx_start2 = 1;
        tick();
        nx_start = 0; nx_start2 = 0;
        run_until_done(700, 1);
        repeat (3) tick();
        pass_end();
        chk("issued2", issued2, 8);
        chk("received2", recv2, 8);
        chk("done2_count", done2, 1);

        // Backpressure at word 100.
        start_pass(2);
        for (int i = 0; i < 300 && recv < 100; i++) tick();
        chk("reach_100", recv, 100);
        nx_ready = 0;
        repeat (20) tick();
        chk("stall_re", s_re, 0);
        chk("stall_valid", s_valid, 1);
        chk("credit", issued - recv, 4);
        nx_ready = 1;
        run_until_done(700, 0);
        repeat (3) tick();
        pass_end();

        // Start while the crossbar is busy, then a busy pulse mid-issue.
        mode = 2;
        pass_init();
        nx_busy = 1; nx_start = 1;
        tick();
        chk("wait_re0", s_re, 0);
        nx_start = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("wait_busy", s_busy, 1);
            chk("wait_re", s_re, 0);
        end
        nx_busy = 0;
        tick();
        chk("fall_cycle_re", s_re, 0);
        tick();
        chk("first_issue_re", s_re, 1);
        repeat (50) tick();
        nx_busy = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_busy_re", s_re, 0);
        end
        nx_busy = 0;
        run_until_done(700, 0);
        repeat (3) tick();
        pass_end();

        // Asynchronous reset at word 300, then a fresh pass from n=0.
        start_pass(2);
        for (int i = 0; i < 500 && recv < 300; i++) tick();
        chk("reach_300", recv, 300);
        chk("busy_pre_rst", int'(o_busy), 1);
        #1 rst = 1'b0;
        #1;
        chk("arst_valid", int'(o_valid), 0);
        chk("arst_busy", int'(o_busy), 0);
        chk("arst_re", int'(o_cim_re), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        start_pass(2);
        run_until_done(700, 0);
        repeat (3) tick();
        pass_end();

        // Stray start mid-issue is ignored; back-to-back start right after done.
        start_pass(0);
        repeat (20) tick();
        nx_start = 1;
        tick();
        nx_start = 0;
        run_until_done(700, 0);
        pass_end();
        start_pass(0);
        chk("b2b_idle_busy", s_busy, 0);
        tick();
        chk("b2b_busy", s_busy, 1);
        run_until_done(700, 0);
        repeat (3) tick();
        pass_end();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_func_stream.md
Name: conv_func_stream

Overview:
- Next-generation functional unit for a CIM layer. Reads crossbar column results from all vertical tiles, sums them, and requantises the sum with an arithmetic shift, optional ReLU and saturation.
- Streams the results in order to the next layer over a valid/ready interface.
- Supports a parametrised crossbar read latency, multi-tile horizontal addressing, and backpressure through a credit-limited output FIFO.

Parameters:
- output_size, 512, number of output elements (columns) per layer pass.
- xbar_size, 256, columns per crossbar tile.
- v_cim_tiles, 2, vertical tiles whose results are summed.
- h_cim_tiles, ceil(output_size/xbar_size), horizontal tiles.
- datatype_size, 8, signed width of each tile result.
- output_datatype_size, 8, signed width of o_data.
- cim_latency, 2, cycles from o_cim_re to valid i_data (>=1).
- fifo_depth, cim_latency+2, output FIFO entries.
- out_shift, 0, arithmetic right shift applied to the sum.
- relu_en, 1, 1 clamps negative results to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  start pulse from the controller.
- i_cim_busy  in  1  crossbar computing; reads are not allowed while high.
- o_cim_re  out  1  crossbar read strobe.
- o_cim_addr  out  clog2(xbar_size)  column address.
- o_cim_htile  out  max(1,clog2(h_cim_tiles))  horizontal tile select.
- i_data  in  [datatype_size-1:0] x v_cim_tiles  signed tile results, valid cim_latency cycles after o_cim_re.
- o_data  out  output_datatype_size  result word.
- o_valid  out  1  o_data valid.
- i_ready  in  1  next layer accepts o_data.
- o_busy  out  1  pass in progress.
- o_done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset (rst=0, asynchronous): state S_IDLE; counters, in-flight tracking and FIFO cleared. All outputs are 0, including o_valid, o_busy, o_done and o_cim_re.
- States:
  - S_IDLE: if i_start, go to S_WAIT_CIM when i_cim_busy=1, else to S_ISSUE. i_start is ignored in every other state.
  - S_WAIT_CIM: o_busy=1; go to S_ISSUE in the cycle after i_cim_busy falls.
  - S_ISSUE: o_busy=1. o_cim_re=1 when i_cim_busy=0 AND (in_flight + fifo_count) < fifo_depth; otherwise 0, with no address advance.
  - Issue sequence: element index n runs 0..output_size-1. o_cim_addr = n mod xbar_size (wraps xbar_size-1 to 0). o_cim_htile = n / xbar_size.
  - After issuing n = output_size-1, go to S_DRAIN.
  - S_DRAIN: o_busy=1; go to S_DONE when in_flight=0 and the FIFO is empty (last word handshaken).
  - S_DONE: o_done=1 and o_busy=0 for one cycle, then S_IDLE.
- Datapath, per read:
  - A delay line of cim_latency stages tracks each read; the matching i_data is captured cim_latency cycles after its o_cim_re.
  - sum = signed sum over v_cim_tiles, width datatype_size + clog2(v_cim_tiles+1); no overflow is possible.
  - s = sum >>> out_shift.
  - If relu_en and s < 0, s = 0.
  - Saturate s to [-2^(output_datatype_size-1), 2^(output_datatype_size-1)-1], then push the result into the FIFO in the same cycle as capture.
- Output handshake:
  - o_valid = FIFO not empty; o_data = FIFO head.
  - A transfer occurs when o_valid & i_ready.
  - o_data is held stable while o_valid=1 and i_ready=0.
  - Words are delivered in index order; none are dropped or duplicated.
- Credit rule: push and pop in the same cycle is allowed; the FIFO never overflows, and a full FIFO only stops issue.
- If i_cim_busy rises mid-S_ISSUE: issue pauses; in-flight reads still complete; issue resumes at the next n after busy falls.
- Minimum latency: first o_valid at t0+cim_latency, where t0 is the first o_cim_re cycle.
- Throughput: one word per cycle when i_ready=1 and i_cim_busy=0.

Test Plan:
1. Defaults; i_data = {10,20} for all addresses; i_ready=1 -> 512 words of 30; o_cim_htile=0 for n<256 and 1 after; o_cim_addr wraps 255->0; first o_valid 2 cycles after first o_cim_re; o_done pulses once.
2. Arithmetic: {100,100} -> 127 (saturated); {-50,-30} with relu_en=1 -> 0; with relu_en=0 -> -80; out_shift=2, {40,24} -> 16.
3. Backpressure: i_ready=0 for 20 cycles at word 100 -> o_cim_re stops once in_flight+fifo_count=4; o_data held stable; all 512 words delivered in order after release.
4. i_start with i_cim_busy=1 for 10 cycles -> S_WAIT_CIM, o_busy=1, o_cim_re=0; first o_cim_re the cycle after busy falls. Busy toggled for 5 cycles mid-ISSUE -> no missing or duplicate indices.
5. rst=0 asserted asynchronously at word 300 -> o_valid, o_busy, o_cim_re go 0 immediately. After release, a new i_start yields 512 words starting from n=0.
6. i_start pulsed during S_ISSUE -> ignored, exactly one o_done. o_busy falls in the o_done cycle; a back-to-back i_start the cycle after o_done starts a new pass.
